// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by fetch_stage and if_id_reg.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a new {pc, instr}, hold under stall, flush on redirect.
// Async active-low reset to an invalid NOP at pc 0.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        load,
    input  logic        stall,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (!stall) begin
            // Decode consumed the entry and nothing replaced it; pc/instr keep last value.
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: single-outstanding imem request FSM feeding the IF/ID register.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_squashed_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         squash_q, squash_d;
    logic [31:0]  hold_q;

    logic         req_valid;
    logic         handshake;
    logic         if_id_free;
    logic         load;
    logic         capture;
    logic [31:0]  load_instr;
    logic         fetched_inc;
    logic         squashed_inc;

    assign req_valid        = (state_q == REQ);
    assign handshake        = req_valid && imem_req_ready_i;
    assign if_id_free       = !if_id_valid_o || !stall_i;
    // Gate with reset so no request is advertised while rst_n is held low.
    assign imem_req_valid_o = req_valid && rst_n;
    assign imem_req_addr_o  = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            squash_q <= squash_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            hold_q <= imem_rsp_data_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        squash_d     = squash_q;
        load         = 1'b0;
        capture      = 1'b0;
        load_instr   = imem_rsp_data_i;
        fetched_inc  = 1'b0;
        squashed_inc = 1'b0;

        if (redirect_i) begin
            // Redirect overrides stall and every state action.
            pc_d = redirect_pc_i;
            case (state_q)
                REQ: begin
                    if (handshake) begin
                        squash_d = 1'b1;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid_i) begin
                        squash_d     = 1'b0;
                        squashed_inc = 1'b1;
                        state_d      = REQ;
                    end else begin
                        squash_d = 1'b1;
                    end
                end
                default: state_d = REQ;
            endcase
        end else begin
            case (state_q)
                REQ: begin
                    if (handshake) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid_i) begin
                        if (squash_q) begin
                            squash_d     = 1'b0;
                            squashed_inc = 1'b1;
                            state_d      = REQ;
                        end else if (if_id_free) begin
                            load        = 1'b1;
                            pc_d        = pc_q + PC_STEP;
                            fetched_inc = 1'b1;
                            state_d     = REQ;
                        end else begin
                            capture = 1'b1;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        load        = 1'b1;
                        load_instr  = hold_q;
                        pc_d        = pc_q + PC_STEP;
                        fetched_inc = 1'b1;
                        state_d     = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_i),
        .load       (load),
        .stall      (stall_i),
        .load_pc    (pc_q),
        .load_instr (load_instr),
        .valid      (if_id_valid_o),
        .pc         (if_id_pc_o),
        .instr      (if_id_instr_o)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q;
    logic [31:0] squashed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q  <= '0;
            squashed_q <= '0;
        end else begin
            if (fetched_inc) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (squashed_inc) begin
                squashed_q <= squashed_q + 32'd1;
            end
        end
    end

    assign perf_fetched_o  = fetched_q;
    assign perf_squashed_o = squashed_q;
`else
    logic unused_perf;
    assign unused_perf     = fetched_inc ^ squashed_inc;
    assign perf_fetched_o  = '0;
    assign perf_squashed_o = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, fetch timing, back-pressure, stall/hold,
// redirect squash, PC wrap (second instance) and mid-request reset.
module tb_fetch_stage;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_ready_i;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;

    logic        req_valid, if_id_valid;
    logic [31:0] req_addr, if_id_pc, if_id_instr, perf_fetched, perf_squashed;
    logic        req_valid2, if_id_valid2;
    logic [31:0] req_addr2, if_id_pc2, if_id_instr2, perf_fetched2, perf_squashed2;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (req_addr),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .if_id_valid_o    (if_id_valid),
        .if_id_pc_o       (if_id_pc),
        .if_id_instr_o    (if_id_instr),
        .perf_fetched_o   (perf_fetched),
        .perf_squashed_o  (perf_squashed)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (req_valid2),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (req_addr2),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .if_id_valid_o    (if_id_valid2),
        .if_id_pc_o       (if_id_pc2),
        .if_id_instr_o    (if_id_instr2),
        .perf_fetched_o   (perf_fetched2),
        .perf_squashed_o  (perf_squashed2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are then driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n            = 1'b0;
        stall_i          = 1'b0;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;

        tick(); tick();
        chk("rst_req_valid",   {31'd0, req_valid},   32'd0);
        chk("rst_if_id_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_if_id_pc",    if_id_pc,             32'h0);
        chk("rst_if_id_instr", if_id_instr,          32'h0000_0013);
        chk("rst_perf_fetch",  perf_fetched,         32'd0);
        chk("rst_perf_squash", perf_squashed,        32'd0);

        // Cycle 1 after release: request to RESET_PC.
        rst_n            = 1'b1;
        imem_req_ready_i = 1'b1;
        #1;
        chk("c1_req_valid",  {31'd0, req_valid}, 32'd1);
        chk("c1_req_addr",   req_addr,           32'h0);
        chk("c1_wrap_addr",  req_addr2,          32'hFFFF_FFFC);

        tick();
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h0050_0093;
        #1;
        chk("c2_req_valid_wait", {31'd0, req_valid}, 32'd0);

        tick();
        imem_rsp_valid_i = 1'b0;
        chk("c3_if_id_valid", {31'd0, if_id_valid}, 32'd1);
        chk("c3_if_id_pc",    if_id_pc,             32'h0);
        chk("c3_if_id_instr", if_id_instr,          32'h0050_0093);
        chk("c3_req_valid",   {31'd0, req_valid},   32'd1);
        chk("c3_next_addr",   req_addr,             32'h4);
        chk("c3_wrap_next",   req_addr2,            32'h0);
        chk("c3_wrap_pc",     if_id_pc2,            32'hFFFF_FFFC);
        chk("c3_perf_fetch",  perf_fetched,         PERF ? 32'd1 : 32'd0);

        // Memory not ready for three cycles: address held, IF/ID drains.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_req_valid",   {31'd0, req_valid},   32'd1);
            chk("bp_addr_held",   req_addr,             32'h4);
            chk("bp_if_id_valid", {31'd0, if_id_valid}, 32'd0);
        end
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h00A0_0113;
        tick();
        imem_rsp_valid_i = 1'b0;
        chk("bp_if_id_valid2", {31'd0, if_id_valid}, 32'd1);
        chk("bp_if_id_pc",     if_id_pc,             32'h4);
        chk("bp_if_id_instr",  if_id_instr,          32'h00A0_0113);
        chk("bp_next_addr",    req_addr,             32'h8);

        // Stall with IF/ID valid: response parks in HOLD.
        stall_i          = 1'b1;
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h0010_8193;
        chk("st_if_id_held", if_id_pc, 32'h4);
        tick();
        imem_rsp_valid_i = 1'b0;
        chk("st_hold_no_req",  {31'd0, req_valid},   32'd0);
        chk("st_hold_valid",   {31'd0, if_id_valid}, 32'd1);
        chk("st_hold_instr",   if_id_instr,          32'h00A0_0113);
        tick();
        chk("st_hold2_pc",     if_id_pc,             32'h4);
        stall_i = 1'b0;
        tick();
        chk("st_rel_valid",    {31'd0, if_id_valid}, 32'd1);
        chk("st_rel_pc",       if_id_pc,             32'h8);
        chk("st_rel_instr",    if_id_instr,          32'h0010_8193);
        chk("st_rel_addr",     req_addr,             32'hC);
        chk("st_rel_req",      {31'd0, req_valid},   32'd1);
        chk("st_perf_fetch",   perf_fetched,         PERF ? 32'd3 : 32'd0);
        tick();
        chk("st_no_dup_valid", {31'd0, if_id_valid}, 32'd0);
        chk("st_no_dup_pc",    if_id_pc,             32'h8);

        // Redirect while in WAIT: in-flight response squashed.
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        redirect_i       = 1'b1;
        redirect_pc_i    = 32'h0000_0100;
        tick();
        redirect_i = 1'b0;
        chk("rd_if_id_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rd_wait_no_req", {31'd0, req_valid},   32'd0);
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid_i = 1'b0;
        chk("rd_req_valid",    {31'd0, req_valid},   32'd1);
        chk("rd_req_addr",     req_addr,             32'h0000_0100);
        chk("rd_if_id_valid2", {31'd0, if_id_valid}, 32'd0);
        chk("rd_instr_kept",   if_id_instr,          32'h0010_8193);
        chk("rd_perf_squash",  perf_squashed,        PERF ? 32'd1 : 32'd0);
        chk("rd_perf_fetch",   perf_fetched,         PERF ? 32'd3 : 32'd0);

        // Redirect in REQ without handshake: new address next cycle.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        tick();
        redirect_i = 1'b0;
        chk("rq_redirect_addr", req_addr, 32'h0000_0200);

        // Reset asserted while WAITing; stray response afterwards is ignored.
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        rst_n            = 1'b0;
        #1;
        chk("ar_req_valid",    {31'd0, req_valid},   32'd0);
        chk("ar_if_id_valid",  {31'd0, if_id_valid}, 32'd0);
        chk("ar_if_id_pc",     if_id_pc,             32'h0);
        chk("ar_if_id_instr",  if_id_instr,          32'h0000_0013);
        chk("ar_req_addr",     req_addr,             32'h0);
        chk("ar_perf_fetch",   perf_fetched,         32'd0);
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h0000_0BAD;
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_stray_valid",  {31'd0, if_id_valid}, 32'd0);
        chk("ar_stray_instr",  if_id_instr,          32'h0000_0013);
        chk("ar_stray_req",    {31'd0, req_valid},   32'd1);
        chk("ar_stray_addr",   req_addr,             32'h0);
        imem_rsp_valid_i = 1'b0;
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h0000_0513;
        tick();
        imem_rsp_valid_i = 1'b0;
        chk("ar_refetch_valid", {31'd0, if_id_valid}, 32'd1);
        chk("ar_refetch_pc",    if_id_pc,             32'h0);
        chk("ar_refetch_instr", if_id_instr,          32'h0000_0513);
        chk("ar_refetch_addr",  req_addr,             32'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage with integrated IF/ID pipeline register, directly upstream of decode and the immediate generator. Holds the PC, issues word fetches to instruction memory over a valid/ready request channel with a single outstanding request, and presents `{pc, instr, valid}` to decode. Handles decode back-pressure (stall) and control-flow redirects from execute, squashing any in-flight response.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `stall_i` in 1: decode cannot accept; hold IF/ID.
- `redirect_i` in 1: one-cycle pulse; redirect fetch.
- `redirect_pc_i` in 32: redirect target, sampled when `redirect_i`=1.
- `imem_req_valid_o` out 1: fetch request valid.
- `imem_req_ready_i` in 1: memory accepts request.
- `imem_req_addr_o` out 32: word address (bits [1:0] = 0 for aligned PCs).
- `imem_rsp_valid_i` in 1: response data valid.
- `imem_rsp_data_i` in 32: fetched instruction.
- `if_id_valid_o` out 1: IF/ID holds a live instruction.
- `if_id_pc_o` out 32: PC of that instruction.
- `if_id_instr_o` out 32: instruction word to decode/imm generator.
- `perf_fetched_o` out 32: instructions delivered to IF/ID.
- `perf_squashed_o` out 32: responses discarded by redirect.

Clock is `clk`; reset `rst_n` is asynchronous, active-low.

## Operation
- FSM states: REQ (request outstanding-to-be-issued), WAIT (request accepted, awaiting response), HOLD (response captured, IF/ID stalled).
- REQ: `imem_req_valid_o`=1, `imem_req_addr_o`=`pc_q`. On `valid&&ready` -> WAIT. Address stable while `valid&&!ready`, except on redirect.
- WAIT: on `imem_rsp_valid_i`:
  - squash flag set: discard data, clear flag, `perf_squashed` +1, -> REQ.
  - IF/ID free (`!if_id_valid_o || !stall_i`): load IF/ID with `{pc_q, data}`, valid=1, `pc_q`+=4, `perf_fetched` +1, -> REQ.
  - else: capture into hold register, -> HOLD.
- HOLD: when `!stall_i`, move hold to IF/ID, `pc_q`+=4, `perf_fetched` +1, -> REQ.
- IF/ID with `stall_i`=0 and nothing new loaded: `if_id_valid_o`<=0 (instr/pc keep last value).
- Redirect (highest priority, overrides stall and all state actions): `pc_q`<=`redirect_pc_i`; `if_id_valid_o`<=0; hold discarded.
  - REQ without handshake: stay REQ, new address next cycle.
  - REQ with handshake this cycle, or WAIT without response this cycle: set squash, -> WAIT.
  - WAIT with response this cycle: discard it (`perf_squashed` +1), -> REQ.
  - HOLD: -> REQ.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. Counters wrap.
- Responses never arrive in the same cycle as their request handshake; at most one outstanding.

## Timing
- Reset values: state REQ, `pc_q`=`RESET_PC`, `if_id_valid_o`=0, `if_id_pc_o`=0, `if_id_instr_o`=32'h0000_0013 (NOP), squash=0, counters 0. `imem_req_valid_o`=0 while `rst_n`=0; 1 in first cycle after release.
- Zero-wait memory: handshake cycle N, response N+1, IF/ID valid from N+2, next request issued N+2. Peak throughput 1 instr / 2 cycles.
- Redirect in cycle N: `if_id_valid_o`=0 from N+1; request to new target visible N+1 (REQ path) or after squashed response.
- Reset asserted mid-request: all state returns to reset values immediately; any later stale response is ignored until next handshake.

## Configuration
- `FETCH_PERF_CNT_EN`: defined -> `perf_fetched_o`/`perf_squashed_o` are live 32-bit counters as above. Undefined -> no counter flops; both ports tied to 0.

## Structure
- `fetch_pkg`: state enum `fetch_state_e` {REQ, WAIT, HOLD}, `NOP_INSTR` = 32'h0000_0013, `PC_STEP` = 4.
- Sub-module `if_id_reg`: IF/ID register with load, stall-hold, flush, async active-low reset to NOP/valid=0.

## Test plan
- Reset release, ready=1, 1-cycle response 32'h00500093 -> req addr 0 at cycle 1, `if_id_valid_o`=1, pc=0, instr=32'h00500093 at cycle 3; next addr 4.
- `imem_req_ready_i`=0 for 3 cycles -> addr held at same PC, no IF/ID load, then normal fetch.
- `stall_i`=1 with IF/ID valid, response arrives -> HOLD; release stall -> held instr appears next cycle, no instruction lost or duplicated.
- Redirect to 32'h0000_0100 while in WAIT -> pending response discarded, `perf_squashed_o`=1, next request addr 0x100, `if_id_valid_o`=0.
- `RESET_PC`=32'hFFFF_FFFC -> second fetch address 32'h0000_0000.
- `rst_n` pulled low while in WAIT -> outputs at reset values immediately; subsequent stray `imem_rsp_valid_i` ignored.
